// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants.
//   UART_TX_FIFO_DEPTH  default TX FIFO depth (entries)
//   uart_fifo_status_t  FIFO status bundle consumed by the CSR block.
//                       The level field is sized for the largest supported
//                       depth (256 -> 9 bits) and zero-extended from the FIFO.
package uart_pkg;

  localparam int UART_TX_FIFO_DEPTH = 16;
  localparam int UART_FIFO_LVL_MAX_W = 9;

  typedef struct packed {
    logic                           empty;
    logic                           full;
    logic                           thr_irq;
    logic                           overflow;
    logic [UART_FIFO_LVL_MAX_W-1:0] level;
  } uart_fifo_status_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: bus/handshake bundle of the TX FIFO.
//   Write side : i_wr_en, i_wr_data, o_full
//   Read side  : o_valid, i_ready, o_data, o_empty
//   Control    : i_flush, i_threshold, i_overflow_clr
//   Status     : o_level, o_thr_irq, o_overflow, o_status
// Handshake: the head moves only on a cycle where o_valid && i_ready are
// both high at the rising edge; o_data is stable while o_valid is high and
// i_ready is low. A write is taken when i_wr_en is high and o_full was low
// at the start of that cycle.
// Modports: slave = FIFO side, master = producer/consumer/CSR side.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_TX_FIFO_DEPTH,
  parameter int DATA_W = 8,
  parameter int LVL_W  = $clog2(DEPTH) + 1
);
  logic              i_wr_en;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_full;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_empty;
  logic [LVL_W-1:0]  o_level;
  logic              i_flush;
  logic [LVL_W-1:0]  i_threshold;
  logic              o_thr_irq;
  logic              o_overflow;
  logic              i_overflow_clr;
  uart_fifo_status_t o_status;

  modport slave (
    input  i_wr_en, i_wr_data, i_ready, i_flush, i_threshold, i_overflow_clr,
    output o_full, o_valid, o_data, o_empty, o_level, o_thr_irq, o_overflow,
           o_status
  );

  modport master (
    output i_wr_en, i_wr_data, i_ready, i_flush, i_threshold, i_overflow_clr,
    input  o_full, o_valid, o_data, o_empty, o_level, o_thr_irq, o_overflow,
           o_status
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x DATA_W register array, one synchronous write port
// and one asynchronous read port. Contents are not reset.
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational from the array)
module uart_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through transmit byte FIFO.
//   i_clk   clock
//   i_nrst  synchronous active-low reset
//   bus     uart_tx_fifo_if.slave: write port, valid/ready head port,
//           flush, threshold interrupt, sticky overflow and status struct.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// with all DEPTH entries usable.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_TX_FIFO_DEPTH,
  parameter int DATA_W = 8
) (
  input  logic            i_clk,
  input  logic            i_nrst,
  uart_tx_fifo_if.slave   bus
);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int AW    = $clog2(DEPTH);

  logic [LVL_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             empty, full;
  logic             wr_acc, rd_acc;
  logic             overflow;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                 (wr_ptr[LVL_W-1] != rd_ptr[LVL_W-1]);
  assign level = wr_ptr - rd_ptr;

  // Full is the registered value from the start of the cycle, so a write
  // into a full FIFO is refused even if the head pops in the same cycle.
  assign wr_acc = bus.i_wr_en && !full;
  assign rd_acc = !empty && bus.i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (bus.i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      end
      // Set beats clear; a flushed write is ignored and cannot set it.
      if (bus.i_wr_en && full && !bus.i_flush) overflow <= 1'b1;
      else if (bus.i_overflow_clr)             overflow <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (i_clk),
    .we    (wr_acc && !bus.i_flush),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.i_wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (bus.o_data)
  );

  assign bus.o_empty    = empty;
  assign bus.o_full     = full;
  assign bus.o_valid    = !empty;
  assign bus.o_level    = level;
  assign bus.o_thr_irq  = (level <= bus.i_threshold);
  assign bus.o_overflow = overflow;

  always_comb begin
    bus.o_status          = '0;
    bus.o_status.empty    = empty;
    bus.o_status.full     = full;
    bus.o_status.thr_irq  = (level <= bus.i_threshold);
    bus.o_status.overflow = overflow;
    bus.o_status.level    = UART_FIFO_LVL_MAX_W'(level);
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: table vectors, directed multi-cycle sequences and
// randomized traffic against a queue-based reference model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int LW    = 5;

  // ---------------- clock / reset ----------------
  logic clk;
  logic nrst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH), .DATA_W(DW)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (bus)
  );

  // ---------------- scoreboard / model ----------------
  logic [DW-1:0] exp_q[$];
  bit            m_ovf;
  int            n_vec;
  int            n_err;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int sz;
    sz = exp_q.size();
    chk("level",    int'(bus.o_level),    sz);
    chk("empty",    int'(bus.o_empty),    int'(sz == 0));
    chk("valid",    int'(bus.o_valid),    int'(sz != 0));
    chk("full",     int'(bus.o_full),     int'(sz == DEPTH));
    chk("thr_irq",  int'(bus.o_thr_irq),  int'(sz <= int'(bus.i_threshold)));
    chk("overflow", int'(bus.o_overflow), int'(m_ovf));
    chk("st_level", int'(bus.o_status.level), sz);
    if (sz != 0) chk("data", int'(bus.o_data), int'(exp_q[0]));
  endtask

  // One clock: model reacts to the inputs held across the edge, then the
  // outputs are compared on the falling edge.
  task automatic cycle();
    int sz;
    bit wr_a, rd_a;
    sz = exp_q.size();
    @(posedge clk);
    if (!nrst) begin
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (bus.i_wr_en && sz == DEPTH && !bus.i_flush) m_ovf = 1'b1;
      else if (bus.i_overflow_clr)                    m_ovf = 1'b0;
      if (bus.i_flush) exp_q.delete();
      else begin
        rd_a = bus.i_ready && sz > 0;
        wr_a = bus.i_wr_en && sz < DEPTH;
        if (rd_a) void'(exp_q.pop_front());
        if (wr_a) exp_q.push_back(bus.i_wr_data);
      end
    end
    @(negedge clk);
    check_model();
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit wr, input logic [DW-1:0] d, input bit rdy,
                       input bit fl, input bit clr);
    bus.i_wr_en        = wr;
    bus.i_wr_data      = d;
    bus.i_ready        = rdy;
    bus.i_flush        = fl;
    bus.i_overflow_clr = clr;
    cycle();
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          ready;
    logic          flush;
    logic [LW-1:0] thr;
    logic [LW-1:0] exp_level;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic          exp_irq;
  } vec_t;

  vec_t tbl[15];

  logic [DW-1:0] sent[$];
  logic [DW-1:0] recv[$];

  initial begin
    // wr, data, rdy, flush, thr | level, valid, data, irq
    tbl[0]  = '{1, 8'hA5, 0, 0, 5'd0, 5'd1, 1, 8'hA5, 0};
    tbl[1]  = '{1, 8'h3C, 0, 0, 5'd0, 5'd2, 1, 8'hA5, 0};
    tbl[2]  = '{1, 8'hFF, 0, 0, 5'd0, 5'd3, 1, 8'hA5, 0};
    tbl[3]  = '{0, 8'h00, 1, 0, 5'd0, 5'd2, 1, 8'h3C, 0};
    tbl[4]  = '{0, 8'h00, 1, 0, 5'd0, 5'd1, 1, 8'hFF, 0};
    tbl[5]  = '{0, 8'h00, 1, 0, 5'd0, 5'd0, 0, 8'h00, 1};
    tbl[6]  = '{1, 8'h01, 0, 0, 5'd2, 5'd1, 1, 8'h01, 1};
    tbl[7]  = '{1, 8'h02, 0, 0, 5'd2, 5'd2, 1, 8'h01, 1};
    tbl[8]  = '{1, 8'h03, 0, 0, 5'd2, 5'd3, 1, 8'h01, 0};
    tbl[9]  = '{1, 8'h04, 0, 0, 5'd2, 5'd4, 1, 8'h01, 0};
    tbl[10] = '{1, 8'h05, 0, 0, 5'd2, 5'd5, 1, 8'h01, 0};
    tbl[11] = '{0, 8'h00, 1, 0, 5'd2, 5'd4, 1, 8'h02, 0};
    tbl[12] = '{0, 8'h00, 1, 0, 5'd2, 5'd3, 1, 8'h03, 0};
    tbl[13] = '{0, 8'h00, 1, 0, 5'd2, 5'd2, 1, 8'h04, 1};
    tbl[14] = '{1, 8'h99, 0, 1, 5'd2, 5'd0, 0, 8'h00, 1};

    n_vec = 0;
    n_err = 0;
    m_ovf = 1'b0;
    nrst  = 1'b0;
    bus.i_wr_en = 1'b0; bus.i_wr_data = '0; bus.i_ready = 1'b0;
    bus.i_flush = 1'b0; bus.i_overflow_clr = 1'b0; bus.i_threshold = '0;

    // reset
    @(negedge clk);
    idle();
    nrst = 1'b1;
    chk("rst_empty", int'(bus.o_empty), 1);
    chk("rst_irq",   int'(bus.o_thr_irq), 1);

    // latency: no same-cycle bypass into an empty FIFO
    bus.i_wr_en = 1'b1; bus.i_wr_data = 8'hA5;
    #1 chk("no_bypass_valid", int'(bus.o_valid), 0);
    bus.i_wr_en = 1'b0;

    // tests 1 and 5 from the table
    for (int i = 0; i < 15; i++) begin
      bus.i_threshold = tbl[i].thr;
      drive(tbl[i].wr_en, tbl[i].wr_data, tbl[i].ready, tbl[i].flush, 1'b0);
      chk($sformatf("tbl%0d_level", i), int'(bus.o_level), int'(tbl[i].exp_level));
      chk($sformatf("tbl%0d_valid", i), int'(bus.o_valid), int'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_irq", i),   int'(bus.o_thr_irq), int'(tbl[i].exp_irq));
      if (tbl[i].exp_valid)
        chk($sformatf("tbl%0d_data", i), int'(bus.o_data), int'(tbl[i].exp_data));
    end
    chk("flush_ovf", int'(bus.o_overflow), 0);
    bus.i_threshold = 5'd4;

    // test 2: fill, overflow, drain, clear
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("t2_full", int'(bus.o_full), 1);
    chk("t2_level", int'(bus.o_level), 16);
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("t2_ovf", int'(bus.o_overflow), 1);
    for (int i = 0; i < 16; i++) begin
      chk("t2_drain", int'(bus.o_data), i);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("t2_empty", int'(bus.o_empty), 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t2_ovf_clr", int'(bus.o_overflow), 0);

    // test 3: write + pop while full
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("t3_level", int'(bus.o_level), 15);
    chk("t3_ovf", int'(bus.o_overflow), 1);
    chk("t3_head", int'(bus.o_data), 8'h81);
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    chk("t3_level2", int'(bus.o_level), 16);
    chk("t3_ovf_clr", int'(bus.o_overflow), 0);
    drive(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);  // set overflow again

    // test 6: reset mid-stream at level 7
    for (int i = 0; i < 9; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t6_level7", int'(bus.o_level), 7);
    nrst = 1'b0;
    drive(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
    nrst = 1'b1;
    chk("t6_level", int'(bus.o_level), 0);
    chk("t6_valid", int'(bus.o_valid), 0);
    chk("t6_ovf", int'(bus.o_overflow), 0);
    chk("t6_empty", int'(bus.o_empty), 1);
    drive(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    chk("t6_resume", int'(bus.o_data), 8'hC3);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // test 4: 40-byte stream, random ready, writes paced by model fill
    begin
      int n_sent;
      int budget;
      n_sent = 0;
      budget = 0;
      while ((n_sent < 40 || exp_q.size() != 0) && budget < 1000) begin
        bit wr, rdy;
        logic [DW-1:0] d;
        wr  = (n_sent < 40) && (exp_q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
        rdy = $urandom_range(0, 1) == 1;
        d   = 8'($urandom);
        if (bus.o_valid && rdy) recv.push_back(bus.o_data);
        if (wr) begin
          sent.push_back(d);
          n_sent++;
        end
        drive(wr, d, rdy, 1'b0, 1'b0);
        budget++;
      end
      chk("t4_budget", int'(budget < 1000), 1);
      chk("t4_count", recv.size(), 40);
      for (int i = 0; i < 40 && i < recv.size(); i++)
        chk("t4_order", int'(recv[i]), int'(sent[i]));
    end

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.i_threshold = 5'($urandom_range(0, 16));
      nrst = ($urandom_range(0, 59) != 0);
      drive($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0);
    end
    nrst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
